// File: rtl/phy_rx_serial_to_parallel_if.sv
// Serial lane receive interface: one serial bit in, byte stream and lock status out.
interface phy_rx_serial_to_parallel_if;
   logic       serial_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       comma_seen;

   // Transmitter / lane driver side
   modport master (
      output serial_in,
      input  data_out,
      input  valid_out,
      input  active,
      input  comma_seen
   );

   // Deserializer side
   modport slave (
      input  serial_in,
      output data_out,
      output valid_out,
      output active,
      output comma_seen
   );
endinterface

// File: rtl/phy_rx_serial_to_parallel.sv
// Receive-side deserializer: hunts for the comma byte, locks after LOCK_COUNT
// consecutive byte-spaced commas, then emits one byte every 8 bit clocks.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SEARCH  | hunting for LOCK_COUNT commas exactly 8 bits apart, active=0
// ALIGNED | locked to byte boundary, data bytes emitted, held until reset
module phy_rx_serial_to_parallel #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned LOCK_COUNT = 4
) (
   input logic                         clk_32f,
   input logic                         reset,
   phy_rx_serial_to_parallel_if.slave  rx
);

   typedef enum logic {SEARCH, ALIGNED} state_t;

   localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

   state_t     state_q, state_d;
   logic [6:0] sr_q, sr_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [3:0] comma_cnt_q, comma_cnt_d;
   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       comma_seen_q, comma_seen_d;

   logic [7:0] win;
   logic       is_comma;
   logic       boundary;

   // Only seven history bits are kept; the eighth is the bit arriving now.
   assign win      = {sr_q, rx.serial_in};
   assign is_comma = (win == COMMA);
   assign boundary = (bit_cnt_q == 3'd7);

   // State, shift path and output registers
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state_q      <= SEARCH;
         sr_q         <= '0;
         bit_cnt_q    <= '0;
         comma_cnt_q  <= '0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         comma_seen_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         bit_cnt_q    <= bit_cnt_d;
         comma_cnt_q  <= comma_cnt_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         comma_seen_q <= comma_seen_d;
      end
   end

   // Comma hunt, lock decision and byte delivery
   always_comb begin
      state_d      = state_q;
      sr_d         = win[6:0];
      bit_cnt_d    = bit_cnt_q + 3'd1;
      comma_cnt_d  = comma_cnt_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      comma_seen_d = 1'b0;

      unique case (state_q)
         SEARCH: begin
            if (is_comma) begin
               comma_seen_d = 1'b1;
               if ((comma_cnt_q != 4'd0) && boundary) begin
                  comma_cnt_d = comma_cnt_q + 4'd1;
               end else begin
                  // First comma, or one at the wrong spacing: restart the run here.
                  comma_cnt_d = 4'd1;
                  bit_cnt_d   = 3'd0;
               end
               if (comma_cnt_d == LOCK_CNT) begin
                  state_d   = ALIGNED;
                  bit_cnt_d = 3'd0;
               end
            end else if (boundary && (comma_cnt_q != 4'd0)) begin
               comma_cnt_d = 4'd0;
            end
         end
         ALIGNED: begin
            if (boundary) begin
               if (is_comma) begin
                  comma_seen_d = 1'b1;
               end else begin
                  data_d  = win;
                  valid_d = 1'b1;
               end
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   assign rx.data_out   = data_q;
   assign rx.valid_out  = valid_q;
   assign rx.active     = (state_q == ALIGNED);
   assign rx.comma_seen = comma_seen_q;

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// Self-checking bench for the serial lane deserializer.
module tb_phy_rx_serial_to_parallel;

   localparam logic [7:0] COMMA = 8'hBC;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   phy_rx_serial_to_parallel_if bus ();

   phy_rx_serial_to_parallel #(
      .COMMA      (COMMA),
      .LOCK_COUNT (4)
   ) u_dut (
      .clk_32f (clk),
      .reset   (reset),
      .rx      (bus)
   );

   int         checks = 0;
   int         passed = 0;
   logic [7:0] exp_q[$];
   logic [7:0] last_data;

   // One serial bit; checks the per-cycle outputs and pops the scoreboard on valid.
   task automatic send_bit(input logic b, input logic exp_valid, input logic exp_comma,
                           input string tag);
      logic [7:0] e;
      @(negedge clk);
      bus.serial_in = b;
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid_out !== exp_valid)
         $display("FAIL %s valid_out got %b expected %b", tag, bus.valid_out, exp_valid);
      else passed++;
      checks++;
      if (bus.comma_seen !== exp_comma)
         $display("FAIL %s comma_seen got %b expected %b", tag, bus.comma_seen, exp_comma);
      else passed++;
      checks++;
      if (bus.valid_out === 1'b1) begin
         if (exp_q.size() == 0) begin
            $display("FAIL %s unexpected byte got %h expected none", tag, bus.data_out);
         end else begin
            e = exp_q.pop_front();
            last_data = e;
            if (bus.data_out !== e)
               $display("FAIL %s data_out got %h expected %h", tag, bus.data_out, e);
            else passed++;
         end
      end else begin
         if (bus.data_out !== last_data)
            $display("FAIL %s data_out hold got %h expected %h", tag, bus.data_out, last_data);
         else passed++;
      end
   endtask

   // One byte MSB first; locked says whether the lane was locked before it starts.
   task automatic send_byte(input logic [7:0] b, input logic locked, input logic exp_active,
                            input string tag);
      logic is_c;
      logic expv;
      is_c = (b == COMMA);
      expv = locked && !is_c;
      if (expv) exp_q.push_back(b);
      for (int i = 7; i >= 0; i--)
         send_bit(b[i], (i == 0) && expv, (i == 0) && is_c, tag);
      checks++;
      if (bus.active !== exp_active)
         $display("FAIL %s active got %b expected %b", tag, bus.active, exp_active);
      else passed++;
   endtask

   task automatic lock_seq(input string tag);
      for (int k = 0; k < 4; k++)
         send_byte(COMMA, 1'b0, (k == 3), tag);
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if ({bus.data_out, bus.valid_out, bus.active, bus.comma_seen} !== 11'd0)
         $display("FAIL %s outputs got data=%h valid=%b active=%b comma=%b expected all 0",
                  tag, bus.data_out, bus.valid_out, bus.active, bus.comma_seen);
      else passed++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.serial_in = 1'b0;
      reset = 1'b1;
      #1;
      check_zero("reset");
      exp_q.delete();
      last_data = 8'h00;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
   endtask

   task automatic test_lock();
      lock_seq("lock");
   endtask

   task automatic test_data();
      send_byte(8'hFC, 1'b1, 1'b1, "data_fc");
      send_byte(8'hFD, 1'b1, 1'b1, "data_fd");
      send_byte(8'hCA, 1'b1, 1'b1, "data_ca");
      send_byte(8'h12, 1'b1, 1'b1, "data_12");
   endtask

   task automatic test_idle();
      send_byte(8'h11, 1'b1, 1'b1, "idle_11");
      send_byte(COMMA, 1'b1, 1'b1, "idle_c1");
      send_byte(COMMA, 1'b1, 1'b1, "idle_c2");
      send_byte(8'h05, 1'b1, 1'b1, "idle_05");
   endtask

   task automatic test_broken_lock();
      do_reset();
      for (int k = 0; k < 3; k++) send_byte(COMMA, 1'b0, 1'b0, "broken_run1");
      send_byte(8'h00, 1'b0, 1'b0, "broken_gap");
      for (int k = 0; k < 4; k++) send_byte(COMMA, 1'b0, (k == 3), "broken_run2");
   endtask

   task automatic test_bit_offset();
      logic [2:0] pre;
      do_reset();
      pre = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) send_bit(pre[i], 1'b0, 1'b0, "offset_prefix");
      lock_seq("offset_lock");
      send_byte(8'hA5, 1'b1, 1'b1, "offset_a5");
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'h5A;
      send_byte(8'h3C, 1'b1, 1'b1, "mid_pre");
      for (int i = 7; i > 3; i--) send_bit(b[i], 1'b0, 1'b0, "mid_partial");
      @(negedge clk);
      bus.serial_in = b[3];
      #2;
      reset = 1'b1;
      #1;
      check_zero("mid_async");
      exp_q.delete();
      last_data = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check_zero("mid_held");
      @(negedge clk);
      reset = 1'b0;
      bus.serial_in = 1'b0;
      lock_seq("mid_relock");
      send_byte(8'h77, 1'b1, 1'b1, "mid_77");
   endtask

   initial begin
      reset = 1'b1;
      bus.serial_in = 1'b0;
      last_data = 8'h00;
      test_reset();
      test_lock();
      test_data();
      test_idle();
      test_broken_lock();
      test_bit_offset();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0)
         $display("FAIL scoreboard_drain left %0d expected 0", exp_q.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
